// File: rtl/dma_copy.sv
// Word-granular memory copy engine: one read then one write per 32-bit word over a single valid/ready port.
// Start to first request is 1 cycle; each word takes 4 cycles at unit responder latency; dma_ready stalls indefinitely.
module dma_copy #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 dma_valid,
    output logic                 dma_instr,
    output logic [31:0]          dma_addr,
    output logic [31:0]          dma_wdata,
    output logic [3:0]           dma_wstrb,
    input  logic [31:0]          dma_rdata,
    input  logic                 dma_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [31:0]            r_src;
    logic [31:0]            r_dst;
    logic [31:0]            r_buf;
    logic [CNT_WIDTH-1:0]   r_rem;
    logic                   w_last;
    logic                   w_unused_lsbs;

    // Byte offsets are dropped at latch time, so requests are always word aligned.
    assign w_unused_lsbs = ^{src_addr[1:0], dst_addr[1:0]};
    assign w_last        = (r_rem == CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count != '0) ? S_RD_REQ : S_DONE;
                end
            end
            S_RD_REQ:  w_next = abort ? S_IDLE : S_RD_WAIT;
            S_RD_WAIT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (dma_ready) begin
                    w_next = S_WR_REQ;
                end
            end
            S_WR_REQ:  w_next = abort ? S_IDLE : S_WR_WAIT;
            S_WR_WAIT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (dma_ready) begin
                    w_next = w_last ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src <= '0;
            r_dst <= '0;
            r_buf <= '0;
            r_rem <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src <= {src_addr[31:2], 2'b00};
                        r_dst <= {dst_addr[31:2], 2'b00};
                        r_rem <= word_count;
                    end
                end
                S_RD_WAIT: begin
                    if (dma_ready && !abort) begin
                        r_buf <= dma_rdata;
                    end
                end
                S_WR_WAIT: begin
                    // Address wrap past 0xFFFFFFFC falls out of the 32-bit add.
                    if (dma_ready && !abort) begin
                        r_src <= r_src + 32'd4;
                        r_dst <= r_dst + 32'd4;
                        r_rem <= r_rem - CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dma_instr = 1'b0;

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        dma_valid = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        dma_wstrb = 4'h0;
        case (r_state)
            S_RD_REQ: begin
                dma_valid = 1'b1;
                dma_addr  = r_src;
            end
            S_WR_REQ: begin
                dma_valid = 1'b1;
                dma_addr  = r_dst;
                dma_wdata = r_buf;
                dma_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: randomized responder latency, request log checked against an address/data reference model.
module tb_dma_copy;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [31:0]   dst_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic [31:0]   dma_rdata = '0;
    logic          dma_ready = 1'b0;
    logic          busy, done, dma_valid, dma_instr;
    logic [31:0]   dma_addr, dma_wdata;
    logic [3:0]    dma_wstrb;

    dma_copy #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .dma_valid(dma_valid), .dma_instr(dma_instr), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata),
        .dma_ready(dma_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } req_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    req_t        reqs[$];
    int          done_cyc[$];
    int          busy_cnt = 0;
    int          instr_bad = 0;
    int          rsp_cnt = 0;
    logic [31:0] pend = '0;
    int          lat_min = 1;
    int          lat_max = 1;

    // Memory contents seen by the copy engine: a fixed function of the word address.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Responder plus bus monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        req_t r;
        dma_ready = 1'b0;
        dma_rdata = '0;
        if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                dma_ready = 1'b1;
                dma_rdata = pend;
            end
        end
        if (dma_valid === 1'b1) begin
            r.wr    = (dma_wstrb != 4'h0);
            r.addr  = dma_addr;
            r.wdata = dma_wdata;
            r.wstrb = dma_wstrb;
            r.cyc   = cyc;
            reqs.push_back(r);
            pend    = rd_val(dma_addr);
            rsp_cnt = int'($urandom_range(lat_max, lat_min));
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
        if (dma_instr !== 1'b0) instr_bad++;
    end

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                              output int t, output int br, output int bd, output int bb);
        @(negedge clk);
        br = reqs.size();
        bd = done_cyc.size();
        bb = busy_cnt;
        src_addr = s;
        dst_addr = d;
        word_count = CW'(n);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        word_count = CW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy === 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= budget) begin
            fails++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                              input int t, input int br, input int bd, input int bb,
                              input bit timed, input string nm);
        logic [31:0] sa, da, ea, eb;
        int          nreq;
        req_t        rr, wr;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        nreq = reqs.size() - br;
        tests++;
        if (nreq != 2 * n) begin
            fails++;
            $display("FAIL %s req_count: got %0d, required %0d", nm, nreq, 2 * n);
        end
        for (int i = 0; i < n && 2 * i + 1 < nreq; i++) begin
            rr = reqs[br + 2 * i];
            wr = reqs[br + 2 * i + 1];
            ea = sa + 32'(4 * i);
            eb = da + 32'(4 * i);
            tests++;
            if (rr.wr || rr.addr !== ea || rr.wstrb !== 4'h0 || rr.wdata !== 32'h0) begin
                fails++;
                $display("FAIL %s read%0d: got addr=%h wstrb=%h wdata=%h, required addr=%h wstrb=0 wdata=0",
                         nm, i, rr.addr, rr.wstrb, rr.wdata, ea);
            end
            tests++;
            if (!wr.wr || wr.addr !== eb || wr.wstrb !== 4'hF || wr.wdata !== rd_val(ea)) begin
                fails++;
                $display("FAIL %s write%0d: got addr=%h wstrb=%h wdata=%h, required addr=%h wstrb=f wdata=%h",
                         nm, i, wr.addr, wr.wstrb, wr.wdata, eb, rd_val(ea));
            end
            if (timed) begin
                tests++;
                if (rr.cyc != t + 1 + 4 * i || wr.cyc != t + 3 + 4 * i) begin
                    fails++;
                    $display("FAIL %s timing%0d: got rd@%0d wr@%0d, required rd@%0d wr@%0d",
                             nm, i, rr.cyc - t, wr.cyc - t, 1 + 4 * i, 3 + 4 * i);
                end
            end
        end
        tests++;
        if (done_cyc.size() - bd != 1) begin
            fails++;
            $display("FAIL %s done_count: got %0d, required 1", nm, done_cyc.size() - bd);
        end else begin
            if (timed) begin
                tests++;
                if (done_cyc[bd] != t + 4 * n + 1) begin
                    fails++;
                    $display("FAIL %s done_time: got t+%0d, required t+%0d", nm, done_cyc[bd] - t, 4 * n + 1);
                end
            end
            tests++;
            if (busy_cnt - bb != done_cyc[bd] - t) begin
                fails++;
                $display("FAIL %s busy_cycles: got %0d, required %0d", nm, busy_cnt - bb, done_cyc[bd] - t);
            end
        end
    endtask

    task automatic run_and_check(input logic [31:0] s, input logic [31:0] d, input int n,
                                 input int lmin, input int lmax, input string nm);
        int t, br, bd, bb;
        lat_min = lmin;
        lat_max = lmax;
        start_copy(s, d, n, t, br, bd, bb);
        wait_idle(400);
        check_copy(s, d, n, t, br, bd, bb, (lmax == 1), nm);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dma_valid !== 1'b0 || dma_instr !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got busy=%b done=%b valid=%b instr=%b, required all 0",
                     busy, done, dma_valid, dma_instr);
        end
        tests++;
        if (dma_addr !== 32'h0 || dma_wdata !== 32'h0 || dma_wstrb !== 4'h0) begin
            fails++;
            $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%h, required 0", dma_addr, dma_wdata, dma_wstrb);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (reqs.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got reqs=%0d busy=%b, required 0 and 0", reqs.size(), busy);
        end
    endtask

    task automatic test_single();
        run_and_check(32'h100, 32'h200, 1, 1, 1, "single");
    endtask

    task automatic test_multi_var();
        run_and_check(32'h1003, 32'h8000, 3, 1, 5, "multi_var");
    endtask

    task automatic test_zero();
        run_and_check(32'h40, 32'h80, 0, 1, 1, "zero");
    endtask

    task automatic test_wrap();
        run_and_check(32'hFFFF_FFFC, 32'h0000_0300, 2, 1, 1, "wrap");
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            run_and_check($urandom, $urandom, int'($urandom_range(6, 1)), 1, int'($urandom_range(3, 1)), "random");
        end
    endtask

    task automatic test_abort();
        int t, br, bd, bb, seen, k;
        lat_min = 3;
        lat_max = 3;
        start_copy(32'h2000, 32'h3000, 4, t, br, bd, bb);
        seen = 0;
        k = 0;
        while (k < 200) begin
            if (dma_valid === 1'b1 && dma_wstrb === 4'h0) begin
                seen++;
                if (seen == 2) break;
            end
            @(negedge clk);
            k++;
        end
        tests++;
        if (seen != 2) begin
            fails++;
            $display("FAIL abort_find_read2: got %0d reads, required 2", seen);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_rdwait_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (reqs.size() - br != 3 || done_cyc.size() - bd != 0) begin
            fails++;
            $display("FAIL abort_rdwait_after: got reqs=%0d dones=%0d, required 3 0", reqs.size() - br, done_cyc.size() - bd);
        end
        lat_min = 1;
        lat_max = 1;
        start_copy(32'h4000, 32'h5000, 2, t, br, bd, bb);
        abort = 1'b1;
        tests++;
        if (dma_valid !== 1'b1 || dma_addr !== 32'h4000) begin
            fails++;
            $display("FAIL abort_rdreq_valid: got valid=%b addr=%h, required 1 00004000", dma_valid, dma_addr);
        end
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_rdreq_idle: got busy=%b, required 0", busy);
        end
        repeat (6) @(negedge clk);
        tests++;
        if (reqs.size() - br != 1 || done_cyc.size() - bd != 0) begin
            fails++;
            $display("FAIL abort_rdreq_after: got reqs=%0d dones=%0d, required 1 0", reqs.size() - br, done_cyc.size() - bd);
        end
        run_and_check(32'h6000, 32'h7000, 3, 1, 4, "after_abort");
    endtask

    task automatic test_reset_midcopy();
        int t, br, bd, bb, k;
        lat_min = 3;
        lat_max = 3;
        start_copy(32'h9000, 32'hA000, 3, t, br, bd, bb);
        k = 0;
        while (!(dma_valid === 1'b1 && dma_wstrb === 4'hF) && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (dma_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_midcopy: got valid=%b busy=%b done=%b, required 0 0 0", dma_valid, busy, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (reqs.size() - br != 2 || done_cyc.size() - bd != 0) begin
            fails++;
            $display("FAIL reset_midcopy_after: got reqs=%0d dones=%0d, required 2 0", reqs.size() - br, done_cyc.size() - bd);
        end
        run_and_check(32'hB000, 32'hC000, 2, 1, 1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_var();
        test_zero();
        test_wrap();
        test_random();
        test_abort();
        test_reset_midcopy();
        tests++;
        if (instr_bad != 0) begin
            fails++;
            $display("FAIL dma_instr: got %0d nonzero cycles, required 0", instr_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
